max_pool_2_2: RTL
=================

Name: max_pool_2_2

Overview:
Consumer end of the 2x2 window interface produced by the window generator.
- Takes one 2x2 window per valid cycle, as two 44-bit column words, and reduces it to a single signed maximum.
- Tracks output column/row position across the pooled feature map and flags row-end and frame-end.
- Sits between the window generator and the next conv/FC layer input buffer.

Parameters:
DATA_W, 22, width of one signed ReLU sample
OUT_W, 14, pooled outputs per row (input row length / 2)
OUT_H, 14, pooled rows per frame

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
win_valid  input  1  window present on x_m_1/x_m_2 this cycle
x_m_1  input  2*DATA_W  left column of window: [2*DATA_W-1:DATA_W] = upper-row sample, [DATA_W-1:0] = lower-row sample
x_m_2  input  2*DATA_W  right column of window, same packing
pool_valid  output  1  pool_data valid this cycle
pool_data  output  DATA_W  signed window maximum; 0 when pool_valid=0
pool_row_end  output  1  high with the last output of each pooled row
frame_done  output  1  one-cycle pulse with the last output of the frame (col OUT_W-1, row OUT_H-1)
out_col  output  4  column index of current pool_data
out_row  output  4  row index of current pool_data

Behaviour:
- Reset (async, rstn=0): all pipeline registers, counters and outputs go to 0 immediately. Reset mid-frame discards in-flight windows; the next accepted window after release is treated as (row 0, col 0).
- All comparisons are signed DATA_W-bit. Ties select either operand (values are equal). No width growth, no saturation.
- Stage 1, registered on win_valid:
  - m1 = max(x_m_1 hi, x_m_1 lo)
  - m2 = max(x_m_2 hi, x_m_2 lo)
  - v1 = win_valid (v1 is registered every cycle, so bubbles propagate)
- Stage 2, registered:
  - pool_data = v1 ? max(m1, m2) : 0
  - pool_valid = v1
- Latency: exactly 2 clk from the win_valid cycle to the pool_valid cycle.
- Throughput: one window per cycle; back-to-back windows are accepted. No backpressure; the downstream must always accept.
- Gaps of any length between windows are allowed; pipeline state on invalid cycles does not corrupt later outputs.
- Position counters:
  - col_cnt and row_cnt advance on the cycle pool_valid is emitted.
  - out_col/out_row show the index of the current output, and are held when pool_valid=0.
  - col_cnt wraps OUT_W-1 -> 0 and increments row_cnt.
  - row_cnt wraps OUT_H-1 -> 0.
- pool_row_end = pool_valid & (col_cnt == OUT_W-1).
- frame_done = pool_row_end & (row_cnt == OUT_H-1). It lasts one cycle and is never asserted without pool_valid.
- Frame wrap: after frame_done the next output is (0,0); consecutive frames need no idle cycle.
- x_m_1/x_m_2 are ignored when win_valid=0, including non-zero garbage on those inputs.

Decomposition:
- Shared CNN package:
  - constants DATA_W=22, POOL_OUT_W=14, POOL_OUT_H=14
  - a signed sample typedef of DATA_W bits
- One natural sub-module: max2_s, a combinational signed 2-input max instanced three times (two in stage 1, one in stage 2).
- Counters and flag logic stay in the top module.

Test Plan:
1. Reset: hold rstn=0 with win_valid=1 and arbitrary data -> pool_valid=0, pool_data=0, frame_done=0 throughout.
2. Single window, released after reset:
   - stimulus: x_m_1={22'sd5, -22'sd3}, x_m_2={22'sd7, 22'sd2}, one-cycle win_valid
   - response: pool_valid high exactly 2 cycles later with pool_data=7, out_col=0, out_row=0
3. All-negative window:
   - stimulus: x_m_1={-9, -4}, x_m_2={-6, -12}
   - response: pool_data=-4 (checks signed compare, not unsigned)
4. Back-to-back stream of 14 windows with maxima 1..14:
   - 14 consecutive pool_valid with pool_data 1..14
   - pool_row_end only on the 14th output (out_col=13)
   - out_row then reads 1 on the next output
5. Full frame of 196 windows with random gaps (0-5 idle cycles):
   - exactly 196 outputs matching a reference max model
   - frame_done single pulse on output 196
   - the next window yields out_col=0, out_row=0
6. Reset mid-frame:
   - stimulus: assert rstn=0 after output 50 while windows are in flight; release and send 1 window
   - response: in-flight outputs are dropped; the next output is at (0,0) with the correct max

Source files
------------

// File: rtl/max_pool_2_2_pkg.sv
// Shared CNN constants and sample type for the 2x2 max-pool stage.
package max_pool_2_2_pkg;

    localparam int unsigned DATA_W     = 22;
    localparam int unsigned POOL_OUT_W = 14;
    localparam int unsigned POOL_OUT_H = 14;
    localparam int unsigned CNT_W      = 4;

    typedef logic signed [DATA_W-1:0] sample_t;

endpackage

// File: rtl/max_pool_2_2_if.sv
// Window-in / pooled-sample-out bundle between the window generator and the pool stage.
interface max_pool_2_2_if;
    import max_pool_2_2_pkg::*;

    logic                  win_valid;
    logic [2*DATA_W-1:0]   x_m_1;
    logic [2*DATA_W-1:0]   x_m_2;
    logic                  pool_valid;
    sample_t               pool_data;
    logic                  pool_row_end;
    logic                  frame_done;
    logic [CNT_W-1:0]      out_col;
    logic [CNT_W-1:0]      out_row;

    modport master (
        output win_valid, x_m_1, x_m_2,
        input  pool_valid, pool_data, pool_row_end, frame_done, out_col, out_row
    );

    modport slave (
        input  win_valid, x_m_1, x_m_2,
        output pool_valid, pool_data, pool_row_end, frame_done, out_col, out_row
    );

endinterface

// File: rtl/max_pool_2_2_max2_s.sv
// Combinational signed two-input maximum.
module max2_s
    import max_pool_2_2_pkg::*;
(
    input  sample_t i_a,
    input  sample_t i_b,
    output sample_t o_max
);

    assign o_max = (i_a >= i_b) ? i_a : i_b;

endmodule

// File: rtl/max_pool_2_2.sv
// 2x2 signed max-pool: two-stage reduction with pooled-map column/row tracking.
module max_pool_2_2
    import max_pool_2_2_pkg::*;
#(
    parameter int unsigned OUT_W = POOL_OUT_W,
    parameter int unsigned OUT_H = POOL_OUT_H
) (
    input  logic            clk,
    input  logic            rstn,
    max_pool_2_2_if.slave   bus
);

    sample_t          w_x1_hi, w_x1_lo, w_x2_hi, w_x2_lo;
    sample_t          w_m1, w_m2, w_max;
    sample_t          r_m1, r_m2;
    logic             r_v1;

    sample_t          r_pool_data;
    logic             r_pool_valid;
    logic             r_row_end;
    logic             r_frame_done;
    logic [CNT_W-1:0] r_out_col, r_out_row;

    // Index that the next emitted output will carry
    logic [CNT_W-1:0] r_col_cnt, r_row_cnt;
    logic [CNT_W-1:0] w_col_nxt, w_row_nxt;
    logic             w_last_col, w_last_row;

    assign w_x1_hi = sample_t'(bus.x_m_1[2*DATA_W-1:DATA_W]);
    assign w_x1_lo = sample_t'(bus.x_m_1[DATA_W-1:0]);
    assign w_x2_hi = sample_t'(bus.x_m_2[2*DATA_W-1:DATA_W]);
    assign w_x2_lo = sample_t'(bus.x_m_2[DATA_W-1:0]);

    max2_s u_max_col1 (.i_a(w_x1_hi), .i_b(w_x1_lo), .o_max(w_m1));
    max2_s u_max_col2 (.i_a(w_x2_hi), .i_b(w_x2_lo), .o_max(w_m2));
    max2_s u_max_win  (.i_a(r_m1),    .i_b(r_m2),    .o_max(w_max));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_m1 <= '0;
            r_m2 <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= bus.win_valid;
            if (bus.win_valid) begin
                r_m1 <= w_m1;
                r_m2 <= w_m2;
            end
        end
    end

    always_comb begin
        w_last_col = (r_col_cnt == CNT_W'(OUT_W - 1));
        w_last_row = (r_row_cnt == CNT_W'(OUT_H - 1));
        w_col_nxt  = r_col_cnt + CNT_W'(1);
        w_row_nxt  = r_row_cnt;
        if (w_last_col) begin
            w_col_nxt = '0;
            w_row_nxt = w_last_row ? '0 : r_row_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pool_valid <= 1'b0;
            r_pool_data  <= '0;
            r_row_end    <= 1'b0;
            r_frame_done <= 1'b0;
            r_out_col    <= '0;
            r_out_row    <= '0;
            r_col_cnt    <= '0;
            r_row_cnt    <= '0;
        end else begin
            r_pool_valid <= r_v1;
            r_pool_data  <= r_v1 ? w_max : '0;
            r_row_end    <= r_v1 & w_last_col;
            r_frame_done <= r_v1 & w_last_col & w_last_row;
            if (r_v1) begin
                r_out_col <= r_col_cnt;
                r_out_row <= r_row_cnt;
                r_col_cnt <= w_col_nxt;
                r_row_cnt <= w_row_nxt;
            end
        end
    end

    assign bus.pool_valid   = r_pool_valid;
    assign bus.pool_data    = r_pool_data;
    assign bus.pool_row_end = r_row_end;
    assign bus.frame_done   = r_frame_done;
    assign bus.out_col      = r_out_col;
    assign bus.out_row      = r_out_row;

endmodule
